// File: rtl/jt900h_pkg.sv
// Shared definitions for the jt900h external RAM bus arbiter.
package jt900h_pkg;

  // Arbiter sequencer states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } busarb_state_t;

  // Bus owner codes reported on the owner output
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Default number of wait cycles per access and default DMA starvation limit
  localparam int DEFAULT_WAIT   = 0;
  localparam int DEFAULT_STARVE = 2;

endpackage

// File: rtl/jt900h_busarb.sv
// Arbiter and wait-state sequencer for the shared 16-bit external RAM bus.
// The CPU (port C) and micro-DMA (port D) compete for the bus. DMA normally
// wins, but a CPU bus lock or too many back-to-back DMA grants hand the bus
// to the CPU.
module jt900h_busarb
  import jt900h_pkg::*;
#(
  parameter int WAIT   = DEFAULT_WAIT,
  parameter int STARVE = DEFAULT_STARVE
)(
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        c_req,
  input  logic        c_lock,
  input  logic [23:0] c_addr,
  input  logic [15:0] c_din,
  input  logic [1:0]  c_we,
  output logic        c_ack,
  input  logic        d_req,
  input  logic [23:0] d_addr,
  input  logic [15:0] d_din,
  input  logic [1:0]  d_we,
  output logic        d_ack,
  output logic [15:0] rd_data,
  output logic [23:0] ram_addr,
  output logic [15:0] ram_din,
  output logic [1:0]  ram_we,
  output logic        ram_cs,
  input  logic [15:0] ram_dout,
  output logic        owner
);

  localparam logic [2:0] WAIT_L   = 3'(WAIT);
  localparam logic [3:0] STARVE_L = 4'(STARVE);

  busarb_state_t state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    starve_q, starve_d;
  logic          lock_q, lock_d;
  logic          ack_q, ack_d;
  logic          owner_q, owner_d;
  logic [23:0]   addr_q, addr_d;
  logic [15:0]   din_q, din_d;
  logic [1:0]    we_q, we_d;
  logic [15:0]   rd_q, rd_d;
  logic          grant_dma;

  // Next-state logic: arbitration in IDLE, wait countdown and completion in ACCESS
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    lock_d    = lock_q;
    ack_d     = ack_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    din_d     = din_q;
    we_d      = we_q;
    rd_d      = rd_q;
    grant_dma = 1'b0;
    if (cen) begin
      ack_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!c_lock) begin
            lock_d = 1'b0;
          end
          if (c_req || d_req) begin
            grant_dma = d_req &&
                        !(c_req && ((lock_q && c_lock) || (starve_q == STARVE_L)));
            owner_d = grant_dma ? OWN_DMA : OWN_CPU;
            addr_d  = grant_dma ? d_addr : c_addr;
            din_d   = grant_dma ? d_din : c_din;
            we_d    = grant_dma ? d_we : c_we;
            cnt_d   = WAIT_L;
            state_d = ST_ACCESS;
            if (grant_dma) begin
              if (c_req && (starve_q != STARVE_L)) begin
                starve_d = starve_q + 4'd1;
              end
            end else begin
              starve_d = 4'd0;
              lock_d   = c_lock;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q == 3'd0) begin
            if (we_q == 2'b00) begin
              rd_d = ram_dout;
            end
            ack_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; reset releases the bus immediately and drops any pending ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      starve_q <= 4'd0;
      lock_q   <= 1'b0;
      ack_q    <= 1'b0;
      owner_q  <= OWN_CPU;
      addr_q   <= 24'd0;
      din_q    <= 16'd0;
      we_q     <= 2'b00;
      rd_q     <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
      ack_q    <= ack_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
    end
  end

  // Outputs are decoded from registers only; strobes appear in the last wait cycle
  always_comb begin
    ram_cs   = (state_q == ST_ACCESS);
    ram_we   = ((state_q == ST_ACCESS) && (cnt_q == 3'd0)) ? we_q : 2'b00;
    ram_addr = addr_q & 24'hFF_FFFE;
    ram_din  = din_q;
    rd_data  = rd_q;
    owner    = owner_q;
    c_ack    = ack_q && (owner_q == OWN_CPU);
    d_ack    = ack_q && (owner_q == OWN_DMA);
  end

endmodule

// File: tb/tb_jt900h_busarb.sv
// Directed bench for the RAM bus arbiter: a vector table drives a WAIT=0
// instance through reads, DMA/CPU fairness and bus locking; hand-written
// sequences cover wait states, clock-enable stalls and reset mid-access.
module tb_jt900h_busarb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cen = 1'b1;
   logic        cReq = 1'b0, cLock = 1'b0, dReq = 1'b0;
   logic [23:0] cAddr = '0, dAddr = '0;
   logic [15:0] cDin = '0, dDin = '0, ramDout = '0;
   logic [1:0]  cWe = '0, dWe = '0;

   logic        cAck0, dAck0, ramCs0, owner0;
   logic [15:0] rdData0, ramDin0;
   logic [23:0] ramAddr0;
   logic [1:0]  ramWe0;
   logic        cAck2, dAck2, ramCs2, owner2;
   logic [15:0] rdData2, ramDin2;
   logic [23:0] ramAddr2;
   logic [1:0]  ramWe2;
   logic        cAck3, dAck3, ramCs3, owner3;
   logic [15:0] rdData3, ramDin3;
   logic [23:0] ramAddr3;
   logic [1:0]  ramWe3;

   int nCompared = 0;
   int nMismatched = 0;

   typedef struct packed {
      logic        cr;
      logic        cl;
      logic        dr;
      logic [15:0] dout;
      logic        cs;
      logic [1:0]  we;
      logic        ca;
      logic        da;
      logic        own;
      logic [15:0] rd;
      logic [23:0] addr;
   } vecT;

   vecT vecs [26];

   jt900h_busarb #(.WAIT(0), .STARVE(2)) u0 (
      .rst(rst), .clk(clk), .cen(cen),
      .c_req(cReq), .c_lock(cLock), .c_addr(cAddr), .c_din(cDin), .c_we(cWe), .c_ack(cAck0),
      .d_req(dReq), .d_addr(dAddr), .d_din(dDin), .d_we(dWe), .d_ack(dAck0),
      .rd_data(rdData0), .ram_addr(ramAddr0), .ram_din(ramDin0), .ram_we(ramWe0),
      .ram_cs(ramCs0), .ram_dout(ramDout), .owner(owner0));

   jt900h_busarb #(.WAIT(2), .STARVE(2)) u2 (
      .rst(rst), .clk(clk), .cen(cen),
      .c_req(cReq), .c_lock(cLock), .c_addr(cAddr), .c_din(cDin), .c_we(cWe), .c_ack(cAck2),
      .d_req(dReq), .d_addr(dAddr), .d_din(dDin), .d_we(dWe), .d_ack(dAck2),
      .rd_data(rdData2), .ram_addr(ramAddr2), .ram_din(ramDin2), .ram_we(ramWe2),
      .ram_cs(ramCs2), .ram_dout(ramDout), .owner(owner2));

   jt900h_busarb #(.WAIT(3), .STARVE(2)) u3 (
      .rst(rst), .clk(clk), .cen(cen),
      .c_req(cReq), .c_lock(cLock), .c_addr(cAddr), .c_din(cDin), .c_we(cWe), .c_ack(cAck3),
      .d_req(dReq), .d_addr(dAddr), .d_din(dDin), .d_we(dWe), .d_ack(dAck3),
      .rd_data(rdData3), .ram_addr(ramAddr3), .ram_din(ramDin3), .ram_we(ramWe3),
      .ram_cs(ramCs3), .ram_dout(ramDout), .owner(owner3));

   // Free-running clock
   always #5 clk = ~clk;

   // Compare one observed value against its expected value and keep the tallies
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock edge and settle just after it
   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Drive one table row's inputs, then clock it through
   task automatic applyStimulus(input vecT v);
      cReq    = v.cr;
      cLock   = v.cl;
      dReq    = v.dr;
      ramDout = v.dout;
      stepEdge();
   endtask

   // Hold reset over two edges with all requests idle, release away from the edge
   task automatic resetAll();
      rst   = 1'b1;
      cen   = 1'b1;
      cReq  = 1'b0;
      cLock = 1'b0;
      dReq  = 1'b0;
      cWe   = 2'b00;
      dWe   = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Main test sequence
   initial begin
      logic [1:0] expWeA [6];
      logic       expCsA [6];
      logic       expAckA [6];
      logic [1:0] expWeB [4];
      logic       expCsB [4];
      logic       expAckB [4];

      //            cr  cl  dr  dout     cs  we   ca  da  own rd       addr
      vecs[0]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,2'b00,1'b0,1'b0,1'b0,16'h0000,24'h000000};
      vecs[1]  = '{1'b1,1'b0,1'b0,16'hBEEF,1'b1,2'b00,1'b0,1'b0,1'b0,16'h0000,24'h001234};
      vecs[2]  = '{1'b1,1'b0,1'b0,16'hBEEF,1'b0,2'b00,1'b1,1'b0,1'b0,16'hBEEF,24'h001234};
      vecs[3]  = '{1'b0,1'b0,1'b0,16'hBEEF,1'b0,2'b00,1'b0,1'b0,1'b0,16'hBEEF,24'h001234};
      vecs[4]  = '{1'b1,1'b0,1'b1,16'h1111,1'b1,2'b00,1'b0,1'b0,1'b1,16'hBEEF,24'h000ABC};
      vecs[5]  = '{1'b1,1'b0,1'b1,16'h1111,1'b0,2'b00,1'b0,1'b1,1'b1,16'h1111,24'h000ABC};
      vecs[6]  = '{1'b1,1'b0,1'b1,16'h1111,1'b1,2'b00,1'b0,1'b0,1'b1,16'h1111,24'h000ABC};
      vecs[7]  = '{1'b1,1'b0,1'b1,16'h1111,1'b0,2'b00,1'b0,1'b1,1'b1,16'h1111,24'h000ABC};
      vecs[8]  = '{1'b1,1'b0,1'b1,16'h1111,1'b1,2'b00,1'b0,1'b0,1'b0,16'h1111,24'h001234};
      vecs[9]  = '{1'b1,1'b0,1'b1,16'h1111,1'b0,2'b00,1'b1,1'b0,1'b0,16'h1111,24'h001234};
      vecs[10] = '{1'b1,1'b0,1'b1,16'h1111,1'b1,2'b00,1'b0,1'b0,1'b1,16'h1111,24'h000ABC};
      vecs[11] = '{1'b1,1'b0,1'b1,16'h1111,1'b0,2'b00,1'b0,1'b1,1'b1,16'h1111,24'h000ABC};
      vecs[12] = '{1'b1,1'b0,1'b1,16'h1111,1'b1,2'b00,1'b0,1'b0,1'b1,16'h1111,24'h000ABC};
      vecs[13] = '{1'b1,1'b0,1'b1,16'h1111,1'b0,2'b00,1'b0,1'b1,1'b1,16'h1111,24'h000ABC};
      vecs[14] = '{1'b1,1'b0,1'b1,16'h1111,1'b1,2'b00,1'b0,1'b0,1'b0,16'h1111,24'h001234};
      vecs[15] = '{1'b1,1'b0,1'b1,16'h1111,1'b0,2'b00,1'b1,1'b0,1'b0,16'h1111,24'h001234};
      vecs[16] = '{1'b0,1'b0,1'b0,16'h1111,1'b0,2'b00,1'b0,1'b0,1'b0,16'h1111,24'h001234};
      vecs[17] = '{1'b1,1'b1,1'b0,16'h2222,1'b1,2'b00,1'b0,1'b0,1'b0,16'h1111,24'h001234};
      vecs[18] = '{1'b1,1'b1,1'b1,16'h2222,1'b0,2'b00,1'b1,1'b0,1'b0,16'h2222,24'h001234};
      vecs[19] = '{1'b1,1'b1,1'b1,16'h2222,1'b1,2'b00,1'b0,1'b0,1'b0,16'h2222,24'h001234};
      vecs[20] = '{1'b1,1'b1,1'b1,16'h2222,1'b0,2'b00,1'b1,1'b0,1'b0,16'h2222,24'h001234};
      vecs[21] = '{1'b1,1'b1,1'b1,16'h2222,1'b1,2'b00,1'b0,1'b0,1'b0,16'h2222,24'h001234};
      vecs[22] = '{1'b1,1'b0,1'b1,16'h2222,1'b0,2'b00,1'b1,1'b0,1'b0,16'h2222,24'h001234};
      vecs[23] = '{1'b1,1'b0,1'b1,16'h3333,1'b1,2'b00,1'b0,1'b0,1'b1,16'h2222,24'h000ABC};
      vecs[24] = '{1'b1,1'b0,1'b1,16'h3333,1'b0,2'b00,1'b0,1'b1,1'b1,16'h3333,24'h000ABC};
      vecs[25] = '{1'b0,1'b0,1'b0,16'h3333,1'b0,2'b00,1'b0,1'b0,1'b1,16'h3333,24'h000ABC};

      // Table-driven run on the zero-wait instance
      cAddr = 24'h001235;
      dAddr = 24'h000ABD;
      cDin  = 16'h0000;
      dDin  = 16'h0000;
      resetAll();
      for (int i = 0; i < 26; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("row%0d ram_cs", i),   32'(ramCs0),   32'(vecs[i].cs));
         checkOutput($sformatf("row%0d ram_we", i),   32'(ramWe0),   32'(vecs[i].we));
         checkOutput($sformatf("row%0d c_ack", i),    32'(cAck0),    32'(vecs[i].ca));
         checkOutput($sformatf("row%0d d_ack", i),    32'(dAck0),    32'(vecs[i].da));
         checkOutput($sformatf("row%0d owner", i),    32'(owner0),   32'(vecs[i].own));
         checkOutput($sformatf("row%0d rd_data", i),  32'(rdData0),  32'(vecs[i].rd));
         checkOutput($sformatf("row%0d ram_addr", i), 32'(ramAddr0), 32'(vecs[i].addr));
      end

      // WAIT=3 DMA byte write: strobe only in the fourth access cycle, ack on the fifth edge
      expCsA  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      expWeA  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
      expAckA = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      resetAll();
      dAddr   = 24'h000101;
      dDin    = 16'h00AA;
      dWe     = 2'b01;
      ramDout = 16'hFFFF;
      dReq    = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k == 5) dReq = 1'b0;
         stepEdge();
         checkOutput($sformatf("w3 edge%0d ram_cs", k + 1), 32'(ramCs3), 32'(expCsA[k]));
         checkOutput($sformatf("w3 edge%0d ram_we", k + 1), 32'(ramWe3), 32'(expWeA[k]));
         checkOutput($sformatf("w3 edge%0d d_ack", k + 1),  32'(dAck3),  32'(expAckA[k]));
         checkOutput($sformatf("w3 edge%0d c_ack", k + 1),  32'(cAck3),  32'd0);
         if (k == 0) begin
            checkOutput("w3 ram_addr", 32'(ramAddr3), 32'h000100);
            checkOutput("w3 ram_din",  32'(ramDin3),  32'h00AA);
            checkOutput("w3 owner",    32'(owner3),   32'd1);
         end
      end
      checkOutput("w3 rd_data kept on write", 32'(rdData3), 32'h0000);

      // WAIT=2 CPU write with cen toggling: every cen-low edge must leave outputs frozen
      expCsB  = '{1'b1, 1'b1, 1'b1, 1'b0};
      expWeB  = '{2'b00, 2'b00, 2'b11, 2'b00};
      expAckB = '{1'b0, 1'b0, 1'b0, 1'b1};
      resetAll();
      cAddr = 24'h000010;
      cDin  = 16'h5A5A;
      cWe   = 2'b11;
      cReq  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cen = 1'b1;
         stepEdge();
         checkOutput($sformatf("cen e%0d ram_cs", k), 32'(ramCs2), 32'(expCsB[k]));
         checkOutput($sformatf("cen e%0d ram_we", k), 32'(ramWe2), 32'(expWeB[k]));
         checkOutput($sformatf("cen e%0d c_ack", k),  32'(cAck2),  32'(expAckB[k]));
         cen = 1'b0;
         stepEdge();
         checkOutput($sformatf("cen hold%0d ram_cs", k), 32'(ramCs2), 32'(expCsB[k]));
         checkOutput($sformatf("cen hold%0d ram_we", k), 32'(ramWe2), 32'(expWeB[k]));
         checkOutput($sformatf("cen hold%0d c_ack", k),  32'(cAck2),  32'(expAckB[k]));
      end
      checkOutput("cen ram_din", 32'(ramDin2), 32'h5A5A);
      cReq = 1'b0;
      stepEdge();
      checkOutput("cen ack held while cen low", 32'(cAck2), 32'd1);
      cen = 1'b1;
      stepEdge();
      checkOutput("cen ack single cycle", 32'(cAck2), 32'd0);
      checkOutput("cen bus idle after",   32'(ramCs2), 32'd0);

      // Reset while a WAIT=3 write strobe is on the bus, then a clean restart
      resetAll();
      cAddr = 24'h000020;
      cDin  = 16'h1357;
      cWe   = 2'b10;
      cReq  = 1'b1;
      repeat (4) stepEdge();
      checkOutput("rst pre ram_we", 32'(ramWe3), 32'h2);
      rst = 1'b1;
      #1;
      checkOutput("rst ram_cs", 32'(ramCs3), 32'd0);
      checkOutput("rst ram_we", 32'(ramWe3), 32'd0);
      checkOutput("rst c_ack",  32'(cAck3),  32'd0);
      checkOutput("rst d_ack",  32'(dAck3),  32'd0);
      rst = 1'b0;
      stepEdge();
      checkOutput("restart ram_cs", 32'(ramCs3), 32'd1);
      checkOutput("restart ram_we", 32'(ramWe3), 32'd0);
      repeat (3) stepEdge();
      checkOutput("restart strobe", 32'(ramWe3), 32'h2);
      stepEdge();
      checkOutput("restart c_ack", 32'(cAck3), 32'd1);
      cReq = 1'b0;
      stepEdge();
      checkOutput("restart c_ack drop", 32'(cAck3), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/jt900h_busarb.md
Name: jt900h_busarb

Overview:
Arbiter and wait-state sequencer for the single 16-bit external RAM bus. The bus is shared between the CPU memory controller (port C) and the micro-DMA engine (port D). It serialises word/byte accesses and inserts a programmable number of wait cycles. It returns read data and a one-cycle ack to whichever requester was served.

Parameters:
WAIT, 0, wait cycles (cen-qualified) inserted per access; range 0..7
STARVE, 2, max consecutive DMA grants while the CPU is pending before the CPU is forced a grant

Ports:
rst  input  1  asynchronous active-high reset
clk  input  1  system clock
cen  input  1  clock enable; all state advances only when cen=1
c_req  input  1  CPU access request; held until c_ack
c_lock  input  1  CPU bus lock; while 1 after a CPU grant, DMA cannot win
c_addr  input  24  CPU byte address (bit 0 ignored on bus, word aligned)
c_din  input  16  CPU write data
c_we  input  2  CPU byte write mask {hi,lo}; 00 = read
c_ack  output  1  one-cen-cycle pulse: CPU access complete
d_req  input  1  DMA access request; held until d_ack
d_addr  input  24  DMA byte address
d_din  input  16  DMA write data
d_we  input  2  DMA byte write mask; 00 = read
d_ack  output  1  one-cen-cycle pulse: DMA access complete
rd_data  output  16  read word latched at completion; valid with c_ack/d_ack
ram_addr  output  24  bus address, {addr[23:1],1'b0}
ram_din  output  16  bus write data
ram_we  output  2  bus byte write strobes, asserted only in the last wait cycle
ram_cs  output  1  bus access in progress
ram_dout  input  16  bus read data, sampled in the last access cycle
owner  output  1  0 = CPU, 1 = DMA; owner of current/last access

Behaviour:
- Reset: every output is 0. FSM=IDLE, wait counter=0, starvation counter=0, lock flag=0.
- FSM states:
  - IDLE: on a cen cycle with any req, select a winner. Latch its addr/din/we onto ram_*. Set ram_cs=1, cnt<=WAIT, go to ACCESS.
  - ACCESS: each cen decrements cnt. ram_we=latched mask only when cnt==0. When cnt==0: rd_data<=ram_dout (reads only; writes leave rd_data unchanged), pulse the winner's ack, ram_cs<=0, ram_we<=0, go to IDLE.
- Latency: req seen in IDLE -> ack is WAIT+2 cen cycles later, counting the grant cycle.
- Back-to-back accesses have a minimum one IDLE cen cycle between them. A req still high in the ack cycle is treated as a new request.
- Arbitration in IDLE:
  - If only one requester is pending, it wins.
  - If both are pending, DMA wins unless the lock flag is set or the starvation counter equals STARVE; in either case the CPU wins.
- Lock flag: set at a CPU grant when c_lock=1. Cleared in any IDLE cycle where c_lock=0.
- Starvation counter: increments on a DMA grant while c_req=1, saturating at STARVE. Cleared on any CPU grant.
- Requests are not re-sampled during ACCESS. A req dropped mid-access does not abort the access; the ack is still pulsed.
- With cen=0, all state and outputs hold, and acks stay high if already high. ack width is exactly one cen-qualified cycle.
- WAIT=0: ACCESS lasts a single cen cycle, with ram_we asserted in that cycle.
- Asynchronous reset mid-access: the bus is released immediately (ram_cs=0, ram_we=0) and no ack is given.

Decomposition:
- Shared package jt900h_pkg holds:
  - FSM state encoding (IDLE=1'b0, ACCESS=1'b1);
  - owner codes OWN_CPU=0 and OWN_DMA=1;
  - the default wait constant.
- No sub-module. Arbitration and the wait counter are small enough to stay inline.

Test Plan:
- WAIT=0, c_req read at 0x001234, ram_dout=0xBEEF -> ram_addr=0x001234, c_ack 2 cen cycles after req, rd_data=0xBEEF, owner=0.
- WAIT=3, d_req write addr 0x000101, d_din=0x00AA, d_we=01 -> ram_addr=0x000100. ram_we=01 only in the 4th ACCESS cycle. d_ack 5 cycles after req.
- c_req and d_req held continuously, STARVE=2 -> grant order D,D,C,D,D,C.
- CPU granted with c_lock=1, d_req held -> CPU wins every arbitration until c_lock=0. Then DMA wins next.
- cen toggled 1/0 during a WAIT=2 access -> all outputs frozen on cen=0 cycles. The ack still spans exactly one cen-high cycle.
- rst asserted during ACCESS with ram_we pending -> ram_cs, ram_we, c_ack, d_ack all 0 immediately. The next access starts from IDLE.
